idma_mc_job_sched: RTL



---
 rtl/idma_mc_pkg.sv | 12 +
 rtl/idma_mc_rr_arb.sv | 76 +++++++
 rtl/stream_fifo.sv | 54 +++++
 rtl/idma_mc_job_sched.sv | 133 +++++++++++++
 4 files changed

// File: rtl/idma_mc_pkg.sv
// Shared types and helpers for the multi-channel iDMA job scheduler.
package idma_mc_pkg;

  // Completion counter type; wraps naturally at 2^32-1 -> 0.
  typedef logic [31:0] cnt_t;

  // Width of a channel ID (chan_id_t): clog2 of the channel count, never below 1.
  function automatic int unsigned chan_id_width(input int unsigned num_channels);
    return (num_channels > 1) ? $clog2(num_channels) : 1;
  endfunction

endpackage

// File: rtl/idma_mc_rr_arb.sv
// Channel arbiter with grant lock. Round-robin by default; building with
// IDMA_MC_STRICT_PRIO_EN selects fixed priority (lowest index wins, no pointer).
// Once valid_o is raised without ready_i the grant is frozen until the handshake.
module idma_mc_rr_arb
  import idma_mc_pkg::*;
#(
  parameter int unsigned NumChannels = 4,
  localparam int unsigned IdW = chan_id_width(NumChannels)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumChannels-1:0] req_i,
  input  logic                   en_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [IdW-1:0]         gnt_o
);

  logic           lock_q;
  logic [IdW-1:0] lock_idx_q;
  logic [IdW-1:0] pick;
  logic           hs;

  assign valid_o = en_i & (|req_i);
  assign gnt_o   = lock_q ? lock_idx_q : pick;
  assign hs      = valid_o & ready_i;

`ifdef IDMA_MC_STRICT_PRIO_EN
  // Fixed priority: scan downwards so the lowest requesting index is kept.
  always_comb begin
    pick = '0;
    for (int i = NumChannels - 1; i >= 0; i--) begin
      if (req_i[i]) pick = IdW'(i);
    end
  end
`else
  logic [IdW-1:0] rr_ptr_q;

  // Round-robin: first requester at or after the pointer wins.
  always_comb begin
    logic           found;
    logic [IdW-1:0] idx;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NumChannels; i++) begin
      idx = IdW'((int'(rr_ptr_q) + i) % NumChannels);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Pointer moves to the channel after the granted one, only on a handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (hs) begin
      rr_ptr_q <= (gnt_o == IdW'(NumChannels - 1)) ? '0 : gnt_o + 1'b1;
    end
  end
`endif

  // Freeze the current grant while an offered job waits for the backend.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q <= valid_o & ~ready_i;
      if (valid_o & ~ready_i) lock_idx_q <= gnt_o;
    end
  end

endmodule

// File: rtl/stream_fifo.sv
// Non-fall-through valid/ready FIFO: data pushed in cycle t is visible at data_o
// from t+1. Handshake: a transfer happens on a side exactly when valid and ready
// are both high on a rising clock edge; valid never depends on ready.
module stream_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  T     data_i,
  input  logic valid_i,
  output logic ready_o,
  output T     data_o,
  output logic valid_o,
  input  logic ready_i
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  T                mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ready_o = (cnt_q != CntW'(DEPTH));
  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  // Pointer and occupancy bookkeeping; push and pop in one cycle keep the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  // Storage array; contents are meaningless while the entry is not occupied.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/idma_mc_job_sched.sv
// Multi-channel iDMA job scheduler: per-channel job FIFOs, arbitration onto one
// backend port, in-order tag tracking of outstanding jobs, per-channel completion
// pulse / counter / sticky IRQ. Optional build macro: IDMA_MC_STRICT_PRIO_EN
// (fixed-priority arbitration instead of round-robin).
// All valid/ready pairs: transfer on a rising edge with both high; valid never
// waits for ready, and an offered backend job stays stable until accepted.
module idma_mc_job_sched
  import idma_mc_pkg::*;
#(
  parameter int unsigned NumChannels    = 4,
  parameter int unsigned JobFifoDepth   = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter type         idma_req_t     = logic,
  parameter type         idma_rsp_t     = logic
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  idma_req_t              chan_req_i [NumChannels],
  input  logic [NumChannels-1:0] chan_valid_i,
  output logic [NumChannels-1:0] chan_ready_o,
  output idma_req_t              be_req_o,
  output logic                   be_valid_o,
  input  logic                   be_ready_i,
  input  idma_rsp_t              be_rsp_i,
  input  logic                   be_rsp_valid_i,
  output logic                   be_rsp_ready_o,
  output logic [NumChannels-1:0] chan_done_o,
  output logic [NumChannels-1:0] chan_busy_o,
  output logic [NumChannels-1:0] irq_o,
  input  logic [NumChannels-1:0] irq_clr_i,
  output cnt_t                   done_cnt_o [NumChannels],
  output logic                   spurious_o
);

  localparam int unsigned IdW  = chan_id_width(NumChannels);
  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

  typedef logic [IdW-1:0] chan_id_t;

  idma_req_t              fifo_data [NumChannels];
  logic [NumChannels-1:0] fifo_valid, fifo_pop, cpl_vec, iss_vec;
  logic [OutW-1:0]        out_cnt_q [NumChannels];
  chan_id_t               gnt, tag_head;
  logic                   tag_ready, tag_valid, issue, cpl;
  logic                   unused_rsp;

  // Response payload carries nothing the scheduler needs.
  assign unused_rsp = ^be_rsp_i;

  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    assign iss_vec[c]     = issue & (gnt == chan_id_t'(c));
    assign cpl_vec[c]     = cpl & (tag_head == chan_id_t'(c));
    assign fifo_pop[c]    = iss_vec[c];
    assign chan_busy_o[c] = fifo_valid[c] | (out_cnt_q[c] != '0);

    stream_fifo #(
      .DEPTH (JobFifoDepth),
      .T     (idma_req_t)
    ) i_job_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .data_i  (chan_req_i[c]),
      .valid_i (chan_valid_i[c]),
      .ready_o (chan_ready_o[c]),
      .data_o  (fifo_data[c]),
      .valid_o (fifo_valid[c]),
      .ready_i (fifo_pop[c])
    );
  end

  // A full tag FIFO means MaxOutstanding jobs in flight: stop offering.
  idma_mc_rr_arb #(
    .NumChannels (NumChannels)
  ) i_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (fifo_valid),
    .en_i    (tag_ready),
    .valid_o (be_valid_o),
    .ready_i (be_ready_i),
    .gnt_o   (gnt)
  );

  assign be_req_o       = fifo_data[gnt];
  assign issue          = be_valid_o & be_ready_i;
  assign be_rsp_ready_o = tag_valid;
  assign cpl            = be_rsp_valid_i & tag_valid;

  // Backend completes in order, so the tag FIFO head names the finishing channel.
  stream_fifo #(
    .DEPTH (MaxOutstanding),
    .T     (chan_id_t)
  ) i_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .data_i  (gnt),
    .valid_i (issue),
    .ready_o (tag_ready),
    .data_o  (tag_head),
    .valid_o (tag_valid),
    .ready_i (be_rsp_valid_i)
  );

  // Per-channel in-flight count, used only to derive chan_busy_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NumChannels; c++) out_cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < NumChannels; c++) begin
        if (iss_vec[c] && !cpl_vec[c])      out_cnt_q[c] <= out_cnt_q[c] + 1'b1;
        else if (cpl_vec[c] && !iss_vec[c]) out_cnt_q[c] <= out_cnt_q[c] - 1'b1;
      end
    end
  end

  // Completion side effects: done pulse, counter, sticky IRQ (set beats clear), spurious flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chan_done_o <= '0;
      irq_o       <= '0;
      spurious_o  <= 1'b0;
      for (int c = 0; c < NumChannels; c++) done_cnt_o[c] <= '0;
    end else begin
      chan_done_o <= cpl_vec;
      irq_o       <= cpl_vec | (irq_o & ~irq_clr_i);
      spurious_o  <= spurious_o | (be_rsp_valid_i & ~tag_valid);
      for (int c = 0; c < NumChannels; c++) begin
        if (cpl_vec[c]) done_cnt_o[c] <= done_cnt_o[c] + 32'd1;
      end
    end
  end

endmodule
